// File: rtl/gp_line_dispatch.sv
// Command-stream front end for the line engine: decodes LINE/BASE/NOP/HALT
// words from the command FIFO and replays each line through the engine handshake.
module gp_line_dispatch #(
    parameter logic [31:0] FRAME_BASE_RST = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        resume,
    input  logic        LE_ready,
    output logic [31:0] LE_color,
    output logic [19:0] LE_point,
    output logic        LE_color_valid,
    output logic        LE_point0_valid,
    output logic        LE_point1_valid,
    output logic        LE_trigger,
    output logic [31:0] LE_frame_base,
    output logic        busy,
    output logic        halted,
    output logic        bad_opcode,
    output logic [15:0] line_count
);

    typedef enum logic [3:0] {
        FETCH_HDR, FETCH_P0, FETCH_P1, FETCH_BASE,
        WAIT_LE, SEND_COLOR, SEND_P0, SEND_P1, SEND_TRIG,
        LE_HOLD, LE_BUSY, HALT
    } state_e;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LINE = 8'h01;
    localparam logic [7:0] OP_BASE = 8'h02;
    localparam logic [7:0] OP_HALT = 8'hFF;

    state_e      state_q, state_d;
    logic [23:0] rgb_q, rgb_d;
    logic [19:0] p0_q, p0_d, p1_q, p1_d, point_q, point_d;
    logic [31:0] base_q, base_d;
    logic [15:0] count_q, count_d;
    logic        bad_q, bad_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        color_vld_q, color_vld_d;
    logic        p0_vld_q, p0_vld_d;
    logic        p1_vld_q, p1_vld_d;
    logic        trig_q, trig_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    logic        accept;

    // cmd_ready_q mirrors "state is a fetch state", so it doubles as the accept qualifier
    assign accept = cmd_valid & cmd_ready_q;

    always_comb begin
        state_d = state_q;
        rgb_d   = rgb_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        base_d  = base_q;
        bad_d   = bad_q;
        count_d = count_q;
        if (resume) bad_d = 1'b0;
        case (state_q)
            FETCH_HDR: if (accept) begin
                case (cmd_data[31:24])
                    OP_NOP: ;
                    OP_LINE: begin
                        rgb_d   = cmd_data[23:0];
                        state_d = FETCH_P0;
                    end
                    OP_BASE: state_d = FETCH_BASE;
                    OP_HALT: state_d = HALT;
                    default: bad_d = 1'b1;
                endcase
            end
            FETCH_P0: if (accept) begin
                p0_d    = cmd_data[19:0];
                state_d = FETCH_P1;
            end
            FETCH_P1: if (accept) begin
                p1_d    = cmd_data[19:0];
                state_d = WAIT_LE;
            end
            FETCH_BASE: if (accept) begin
                base_d  = cmd_data;
                state_d = FETCH_HDR;
            end
            WAIT_LE:    if (LE_ready) state_d = SEND_COLOR;
            SEND_COLOR: state_d = SEND_P0;
            SEND_P0:    state_d = SEND_P1;
            SEND_P1:    state_d = SEND_TRIG;
            SEND_TRIG:  state_d = LE_HOLD;
            // engine drops LE_ready only the cycle after trigger, so skip one sample
            LE_HOLD:    state_d = LE_BUSY;
            LE_BUSY:    if (LE_ready) state_d = FETCH_HDR;
            HALT:       if (resume) state_d = FETCH_HDR;
            default:    state_d = FETCH_HDR;
        endcase

        if (state_d == SEND_TRIG) count_d = count_q + 16'd1;

        // outputs are decoded from the next state so they appear as clean flops
        cmd_ready_d = (state_d == FETCH_HDR) || (state_d == FETCH_P0) ||
                      (state_d == FETCH_P1)  || (state_d == FETCH_BASE);
        color_vld_d = (state_d == SEND_COLOR);
        p0_vld_d    = (state_d == SEND_P0);
        p1_vld_d    = (state_d == SEND_P1);
        trig_d      = (state_d == SEND_TRIG);
        point_d     = (state_d == SEND_P1) ? p1_d : p0_d;
        busy_d      = !((state_d == FETCH_HDR) || (state_d == HALT));
        halted_d    = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH_HDR;
            rgb_q       <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            point_q     <= '0;
            base_q      <= FRAME_BASE_RST;
            count_q     <= '0;
            bad_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            color_vld_q <= 1'b0;
            p0_vld_q    <= 1'b0;
            p1_vld_q    <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rgb_q       <= rgb_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            point_q     <= point_d;
            base_q      <= base_d;
            count_q     <= count_d;
            bad_q       <= bad_d;
            cmd_ready_q <= cmd_ready_d;
            color_vld_q <= color_vld_d;
            p0_vld_q    <= p0_vld_d;
            p1_vld_q    <= p1_vld_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign LE_color        = {8'h00, rgb_q};
    assign LE_point        = point_q;
    assign LE_color_valid  = color_vld_q;
    assign LE_point0_valid = p0_vld_q;
    assign LE_point1_valid = p1_vld_q;
    assign LE_trigger      = trig_q;
    assign LE_frame_base   = base_q;
    assign busy            = busy_q;
    assign halted          = halted_q;
    assign bad_opcode      = bad_q;
    assign line_count      = count_q;

endmodule

// File: tb/tb_gp_line_dispatch.sv
// Bench for gp_line_dispatch: command feeder, line-engine model, strobe monitor
// and a command-stream reference model that predicts the replayed lines.
module tb_gp_line_dispatch;

    localparam logic [31:0] BASE_RST = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cmd_data = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        resume = 1'b0;
    logic        LE_ready = 1'b1;
    logic [31:0] LE_color;
    logic [19:0] LE_point;
    logic        LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger;
    logic [31:0] LE_frame_base;
    logic        busy, halted, bad_opcode;
    logic [15:0] line_count;

    gp_line_dispatch #(.FRAME_BASE_RST(BASE_RST)) dut (
        .clk(clk), .rst(rst),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .resume(resume), .LE_ready(LE_ready),
        .LE_color(LE_color), .LE_point(LE_point),
        .LE_color_valid(LE_color_valid), .LE_point0_valid(LE_point0_valid),
        .LE_point1_valid(LE_point1_valid), .LE_trigger(LE_trigger),
        .LE_frame_base(LE_frame_base), .busy(busy), .halted(halted),
        .bad_opcode(bad_opcode), .line_count(line_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] color;
        logic [31:0] base;
        logic [19:0] p0;
        logic [19:0] p1;
        int          c_cyc;
        int          t_cyc;
    } line_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] stage[$];
    logic [31:0] wq[$];
    int          acc_cyc[$];
    int          rise_q[$];
    int          gap_pct = 0;
    int          eng_busy = 2;
    bit          eng_rand = 1'b0;
    line_t       obs_q[$];
    line_t       exp_q[$];
    line_t       cur;
    int          phase = 0;
    int          last_stb = 0;
    int          trig_cnt = 0;
    logic [31:0] m_base = BASE_RST;
    bit          m_bad = 1'b0;
    int          m_count = 0;

    initial forever @(posedge clk) cyc++;

    // command FIFO head: presents wq[0], pops it when the handshake completes
    initial forever begin
        @(negedge clk);
        if (wq.size() > 0 && $urandom_range(99) >= gap_pct) begin
            cmd_valid = 1'b1;
            cmd_data  = wq[0];
            if (cmd_ready === 1'b1 && !rst) begin
                acc_cyc.push_back(cyc);
                void'(wq.pop_front());
            end
        end else begin
            cmd_valid = 1'b0;
            cmd_data  = $urandom;
        end
    end

    // line engine: goes busy the cycle after trigger for eng_busy cycles
    initial forever begin
        @(negedge clk);
        if (LE_trigger === 1'b1 && !rst) begin
            int n;
            n = eng_rand ? $urandom_range(0, 6) : eng_busy;
            @(negedge clk);
            if (n > 0) begin
                LE_ready = 1'b0;
                repeat (n) @(negedge clk);
                LE_ready = 1'b1;
            end
            rise_q.push_back(cyc);
        end
    end

    // strobe monitor: exclusivity, strict color->p0->p1->trigger order on consecutive cycles
    initial forever begin
        int n;
        @(negedge clk);
        if (rst) phase = 0;
        else begin
            n = 0;
            if (LE_color_valid)  n++;
            if (LE_point0_valid) n++;
            if (LE_point1_valid) n++;
            if (LE_trigger)      n++;
            if (n > 0) begin
                checks++;
                if (n > 1) begin
                    errors++;
                    $display("FAIL strobe_overlap cyc=%0d got %0d strobes, want 1", cyc, n);
                end
            end
            if (LE_color_valid) begin
                checks++;
                if (phase != 0) begin
                    errors++;
                    $display("FAIL strobe_order color cyc=%0d phase got %0d want 0", cyc, phase);
                end
                cur.color = LE_color; cur.base = LE_frame_base; cur.c_cyc = cyc;
                phase = 1; last_stb = cyc;
            end else if (LE_point0_valid) begin
                checks++;
                if (phase != 1 || cyc != last_stb + 1) begin
                    errors++;
                    $display("FAIL strobe_order p0 cyc=%0d phase %0d last %0d", cyc, phase, last_stb);
                end
                cur.p0 = LE_point; phase = 2; last_stb = cyc;
            end else if (LE_point1_valid) begin
                checks++;
                if (phase != 2 || cyc != last_stb + 1) begin
                    errors++;
                    $display("FAIL strobe_order p1 cyc=%0d phase %0d last %0d", cyc, phase, last_stb);
                end
                cur.p1 = LE_point; phase = 3; last_stb = cyc;
            end else if (LE_trigger) begin
                checks++;
                if (phase != 3 || cyc != last_stb + 1) begin
                    errors++;
                    $display("FAIL strobe_order trig cyc=%0d phase %0d last %0d", cyc, phase, last_stb);
                end
                cur.t_cyc = cyc; obs_q.push_back(cur); trig_cnt++;
                phase = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // reference model: interprets the staged word stream, then hands it to the feeder
    task automatic issue();
        int i = 0;
        line_t l;
        while (i < stage.size()) begin
            case (stage[i][31:24])
                8'h01: begin
                    l.color = {8'h00, stage[i][23:0]};
                    l.p0 = stage[i+1][19:0];
                    l.p1 = stage[i+2][19:0];
                    l.base = m_base;
                    l.c_cyc = 0; l.t_cyc = 0;
                    exp_q.push_back(l);
                    m_count++;
                    i += 3;
                end
                8'h02: begin m_base = stage[i+1]; i += 2; end
                8'h00, 8'hFF: i++;
                default: begin m_bad = 1'b1; i++; end
            endcase
        end
        foreach (stage[k]) wq.push_back(stage[k]);
        stage.delete();
    endtask

    task automatic add_line(input logic [23:0] rgb, input logic [9:0] x0, input logic [9:0] y0,
                            input logic [9:0] x1, input logic [9:0] y1);
        stage.push_back({8'h01, rgb});
        stage.push_back({12'($urandom), x0, y0});
        stage.push_back({12'($urandom), x1, y1});
    endtask

    task automatic add_rand_line();
        add_line(24'($urandom), 10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
    endtask

    task automatic clear_logs();
        obs_q.delete(); exp_q.delete(); acc_cyc.delete(); rise_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (wq.size() > 0 && n < budget) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        while (!(busy === 1'b0 && LE_ready === 1'b1) && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle timeout after %0d cycles, wq=%0d busy=%b", n, wq.size(), busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger, busy, halted, bad_opcode} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000000",
                     {cmd_ready, LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger, busy, halted, bad_opcode});
        end
        checks++;
        if (LE_color !== 32'h0 || LE_point !== 20'h0 || line_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_data color=%h point=%h count=%h want 0", LE_color, LE_point, line_count);
        end
        checks++;
        if (LE_frame_base !== BASE_RST) begin
            errors++;
            $display("FAIL reset_base got %h want %h", LE_frame_base, BASE_RST);
        end
        rst = 1'b0;
        m_base = BASE_RST; m_bad = 1'b0; m_count = 0;
        @(negedge clk);
    endtask

    task automatic test_line_latency();
        int n;
        clear_logs(); gap_pct = 0; eng_busy = 2; eng_rand = 1'b0;
        add_line(24'hFF0000, 10'h0A, 10'h014, 10'h64, 10'h0C8);
        issue();
        wait_idle(200);
        checks++;
        if (obs_q.size() != 1 || acc_cyc.size() != 3) begin
            errors++;
            $display("FAIL latency_counts lines=%0d accepts=%0d want 1,3", obs_q.size(), acc_cyc.size());
        end else begin
            n = acc_cyc[2];
            checks++;
            if (obs_q[0].c_cyc != n + 2 || obs_q[0].t_cyc != n + 5) begin
                errors++;
                $display("FAIL latency_cycles color@%0d trig@%0d want %0d,%0d", obs_q[0].c_cyc, obs_q[0].t_cyc, n + 2, n + 5);
            end
            checks++;
            if (obs_q[0].color !== 32'h00FF0000 || obs_q[0].p0 !== 20'h02814 || obs_q[0].p1 !== 20'h190C8) begin
                errors++;
                $display("FAIL latency_data color=%h p0=%h p1=%h want 00ff0000,02814,190c8",
                         obs_q[0].color, obs_q[0].p0, obs_q[0].p1);
            end
        end
        checks++;
        if (line_count !== 16'd1) begin
            errors++;
            $display("FAIL latency_count got %0d want 1", line_count);
        end
    endtask

    task automatic test_le_busy();
        clear_logs(); gap_pct = 0; eng_busy = 10;
        add_rand_line(); add_rand_line();
        issue();
        wait_idle(400);
        checks++;
        if (rise_q.size() < 1 || acc_cyc.size() != 6) begin
            errors++;
            $display("FAIL busy_counts rises=%0d accepts=%0d want >=1,6", rise_q.size(), acc_cyc.size());
        end else begin
            checks++;
            if (acc_cyc[3] != rise_q[0] + 1) begin
                errors++;
                $display("FAIL busy_next_hdr accepted@%0d want %0d", acc_cyc[3], rise_q[0] + 1);
            end
        end
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL busy_lines got %0d want 2", obs_q.size());
        end else foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].color !== exp_q[i].color || obs_q[i].p0 !== exp_q[i].p0 || obs_q[i].p1 !== exp_q[i].p1) begin
                errors++;
                $display("FAIL busy_line%0d got %h/%h/%h want %h/%h/%h", i, obs_q[i].color, obs_q[i].p0,
                         obs_q[i].p1, exp_q[i].color, exp_q[i].p0, exp_q[i].p1);
            end
        end
        eng_busy = 2;
    endtask

    task automatic test_base();
        clear_logs(); gap_pct = 0;
        stage.push_back(32'h0200_0000);
        stage.push_back(32'h1040_0000);
        add_rand_line();
        issue();
        wait_idle(200);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL base_lines got %0d want 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].base !== 32'h1040_0000 || obs_q[0].color !== exp_q[0].color) begin
                errors++;
                $display("FAIL base_at_color base=%h color=%h want 10400000,%h", obs_q[0].base, obs_q[0].color, exp_q[0].color);
            end
        end
        checks++;
        if (LE_frame_base !== m_base) begin
            errors++;
            $display("FAIL base_reg got %h want %h", LE_frame_base, m_base);
        end
    endtask

    task automatic test_bad_opcode();
        clear_logs(); gap_pct = 0;
        stage.push_back({8'h37, 24'($urandom)});
        stage.push_back({8'h00, 24'($urandom)});
        issue();
        wait_idle(100);
        checks++;
        if (bad_opcode !== 1'b1 || acc_cyc.size() != 2 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL bad_op flag=%b accepts=%0d lines=%0d want 1,2,0", bad_opcode, acc_cyc.size(), obs_q.size());
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        m_bad = 1'b0;
        checks++;
        if (bad_opcode !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_op_resume flag=%b busy=%b want 0,0", bad_opcode, busy);
        end
    endtask

    task automatic test_halt();
        int n = 0;
        int bad = 0;
        int cnt0;
        clear_logs(); gap_pct = 0;
        cnt0 = m_count;
        stage.push_back(32'hFF00_0000);
        add_rand_line(); add_rand_line(); add_rand_line();
        issue();
        while (halted !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL halt_enter halted=%b want 1", halted);
        end
        repeat (20) begin
            if (halted !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || obs_q.size() != 0 || acc_cyc.size() != 1) begin
            errors++;
            $display("FAIL halt_hold bad_cycles=%0d lines=%0d accepts=%0d want 0,0,1", bad, obs_q.size(), acc_cyc.size());
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        checks++;
        if (halted !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL halt_resume halted=%b cmd_ready=%b want 0,1", halted, cmd_ready);
        end
        wait_idle(500);
        checks++;
        if (obs_q.size() != 3 || line_count !== 16'(m_count) || m_count - cnt0 != 3) begin
            errors++;
            $display("FAIL halt_lines lines=%0d count=%0d want 3,%0d", obs_q.size(), line_count, m_count);
        end else foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].color !== exp_q[i].color || obs_q[i].p0 !== exp_q[i].p0 || obs_q[i].p1 !== exp_q[i].p1) begin
                errors++;
                $display("FAIL halt_line%0d got %h/%h/%h want %h/%h/%h", i, obs_q[i].color, obs_q[i].p0,
                         obs_q[i].p1, exp_q[i].color, exp_q[i].p0, exp_q[i].p1);
            end
        end
    endtask

    task automatic test_random();
        int r;
        clear_logs(); gap_pct = 30; eng_rand = 1'b1;
        for (int c = 0; c < 40; c++) begin
            r = $urandom_range(99);
            if (r < 60) add_rand_line();
            else if (r < 72) begin
                stage.push_back({8'h02, 24'($urandom)});
                stage.push_back($urandom);
            end else if (r < 86) stage.push_back({8'h00, 24'($urandom)});
            else stage.push_back({8'($urandom_range(3, 254)), 24'($urandom)});
        end
        issue();
        wait_idle(8000);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_lines got %0d want %0d", obs_q.size(), exp_q.size());
        end else foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].color !== exp_q[i].color || obs_q[i].p0 !== exp_q[i].p0 ||
                obs_q[i].p1 !== exp_q[i].p1 || obs_q[i].base !== exp_q[i].base) begin
                errors++;
                $display("FAIL rand_line%0d got %h/%h/%h/%h want %h/%h/%h/%h", i, obs_q[i].color, obs_q[i].p0,
                         obs_q[i].p1, obs_q[i].base, exp_q[i].color, exp_q[i].p0, exp_q[i].p1, exp_q[i].base);
            end
        end
        checks++;
        if (line_count !== 16'(m_count) || bad_opcode !== m_bad || LE_frame_base !== m_base) begin
            errors++;
            $display("FAIL rand_state count=%0d bad=%b base=%h want %0d,%b,%h",
                     line_count, bad_opcode, LE_frame_base, m_count, m_bad, m_base);
        end
        gap_pct = 0; eng_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int t0;
        clear_logs(); gap_pct = 0; eng_busy = 2;
        add_rand_line();
        issue();
        while (LE_point0_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL rstmid_reach point0_valid never seen");
        end
        t0 = trig_cnt;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger, busy, halted, bad_opcode} !== 8'b1000_0000 ||
            LE_color !== 32'h0 || LE_point !== 20'h0 || LE_frame_base !== BASE_RST || line_count !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_outputs flags=%b color=%h point=%h base=%h count=%0d want reset values",
                     {cmd_ready, LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger, busy, halted, bad_opcode},
                     LE_color, LE_point, LE_frame_base, line_count);
        end
        rst = 1'b0;
        m_base = BASE_RST; m_bad = 1'b0; m_count = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (trig_cnt != t0 || line_count !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after triggers=%0d count=%0d busy=%b want %0d,0,0", trig_cnt, line_count, busy, t0);
        end
    endtask

    initial begin
        test_reset();
        test_line_latency();
        test_le_busy();
        test_base();
        test_bad_opcode();
        test_halt();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
